// File: rtl/bus_grant_scheduler.sv
// Weighted round-robin bus grant scheduler: one owner at a time, held for up to
// a per-terminal packet quota, with a watchdog that forces release on a stalled transfer.
module bus_grant_scheduler #(
  parameter int DRVS    = 8,
  parameter int QUOTA_W = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DRVS-1:0]         pndng,
  input  logic                    xfer_done,
  input  logic                    cfg_we,
  input  logic [$clog2(DRVS)-1:0] cfg_idx,
  input  logic [QUOTA_W-1:0]      cfg_quota,
  output logic [DRVS-1:0]         gnt,
  output logic                    gnt_vld,
  output logic [$clog2(DRVS)-1:0] gnt_idx,
  output logic                    timeout_err
);
  localparam int IW   = $clog2(DRVS);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                        state_q;
  logic [DRVS-1:0][QUOTA_W-1:0]  quota_q;
  logic [IW-1:0]                 ptr_q, ptr_d;
  logic [IW-1:0]                 gnt_idx_q;
  logic [DRVS-1:0]               gnt_q;
  logic                          gnt_vld_q, timeout_err_q;
  logic [QUOTA_W:0]              cnt_q, cnt_d, lim_q, sel_lim;
  logic [WD_W-1:0]               wd_q;
  logic [IW-1:0]                 sel_idx;
  logic                          sel_vld;
  logic [QUOTA_W-1:0]            sel_quota;

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % DRVS;
    return IW'(s);
  endfunction

  // Descending scan so the smallest offset from ptr_q wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DRVS-1; i >= 0; i--) begin
      if (pndng[rot(ptr_q, i)]) begin
        sel_vld = 1'b1;
        sel_idx = rot(ptr_q, i);
      end
    end
  end

  assign sel_quota = quota_q[sel_idx];
  assign sel_lim   = (sel_quota == '0) ? (QUOTA_W+1)'(1) : {1'b0, sel_quota};
  assign cnt_d     = cnt_q + 1'b1;
  assign ptr_d     = (int'(gnt_idx_q) == DRVS-1) ? '0 : gnt_idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_idx_q     <= '0;
      gnt_q         <= '0;
      gnt_vld_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      lim_q         <= (QUOTA_W+1)'(1);
      wd_q          <= '0;
      for (int i = 0; i < DRVS; i++) quota_q[i] <= QUOTA_W'(1);
    end else begin
      timeout_err_q <= 1'b0;
      // The owner's limit is latched at grant time, so this never disturbs a live grant.
      if (cfg_we && int'(cfg_idx) < DRVS) quota_q[cfg_idx] <= cfg_quota;

      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            state_q   <= GRANT;
            gnt_q     <= DRVS'(1) << sel_idx;
            gnt_vld_q <= 1'b1;
            gnt_idx_q <= sel_idx;
            cnt_q     <= '0;
            lim_q     <= sel_lim;
            wd_q      <= '0;
          end
        end
        GRANT: begin
          if (xfer_done) begin
            cnt_q <= cnt_d;
            if (cnt_d < lim_q && pndng[gnt_idx_q]) begin
              wd_q <= '0;
            end else begin
              state_q   <= IDLE;
              gnt_q     <= '0;
              gnt_vld_q <= 1'b0;
              ptr_q     <= ptr_d;
            end
          end else if (!pndng[gnt_idx_q]) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= ptr_d;
          end else if (wd_q == WD_W'(TIMEOUT-1)) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            gnt_vld_q     <= 1'b0;
            ptr_q         <= ptr_d;
            timeout_err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_vld     = gnt_vld_q;
  assign gnt_idx     = gnt_idx_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Randomized scoreboard bench: a cycle-level reference model queues expected
// grant/release events; a monitor pops them and checks every output each cycle.
module tb_bus_grant_scheduler;
  localparam int DRVS = 8, QUOTA_W = 4, TIMEOUT = 16, IW = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [DRVS-1:0]    pndng = '0;
  logic               xfer_done = 1'b0;
  logic               cfg_we = 1'b0;
  logic [IW-1:0]      cfg_idx = '0;
  logic [QUOTA_W-1:0] cfg_quota = '0;
  logic [DRVS-1:0]    gnt;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  logic               timeout_err;

  bus_grant_scheduler #(.DRVS(DRVS), .QUOTA_W(QUOTA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .xfer_done(xfer_done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_quota(cfg_quota),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    bit is_grant;
    int idx;
    bit to;
  } ev_t;

  ev_t evq[$];
  int  n_cmp = 0, n_bad = 0;
  int  edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: owner -1 means bus idle; m_t0 is the edge the current wait began.
  int m_owner = -1, m_ptr = 0, m_cnt = 0, m_lim = 1, m_t0 = 0;
  int m_quota[DRVS];

  task automatic m_release(input int e, input bit to);
    evq.push_back('{e, 1'b0, m_owner, to});
    m_ptr   = (m_owner + 1) % DRVS;
    m_owner = -1;
  endtask

  task automatic model_step(input int e);
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      foreach (m_quota[i]) m_quota[i] = 1;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < DRVS; k++) begin
        int p;
        p = (m_ptr + k) % DRVS;
        if (pndng[p]) begin
          m_owner = p;
          m_cnt   = 0;
          m_lim   = (m_quota[p] == 0) ? 1 : m_quota[p];
          m_t0    = e;
          evq.push_back('{e, 1'b1, p, 1'b0});
          break;
        end
      end
    end else if (xfer_done) begin
      m_cnt++;
      if (m_cnt < m_lim && pndng[m_owner]) m_t0 = e;
      else m_release(e, 1'b0);
    end else if (!pndng[m_owner]) begin
      m_release(e, 1'b0);
    end else if (e - m_t0 == TIMEOUT) begin
      m_release(e, 1'b1);
    end
    if (cfg_we) m_quota[cfg_idx] = int'(cfg_quota);
  endtask

  task automatic cyc(input bit rst, input logic [DRVS-1:0] pn, input bit dn,
                     input bit we, input int qi, input int qv);
    @(negedge clk);
    reset     = rst;
    pndng     = pn;
    xfer_done = dn;
    cfg_we    = we;
    cfg_idx   = IW'(qi);
    cfg_quota = QUOTA_W'(qv);
    model_step(edge_cnt + 1);
  endtask

  function automatic bit gdone(input int n);
    if (m_owner >= 0) return $urandom_range(0, n-1) == 0;
    return $urandom_range(0, 9) == 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp);
    end
  endtask

  // Monitor
  int              mon_own = -1, mon_idx = 0;
  logic [DRVS-1:0] mon_gnt;
  bit              mon_to;
  ev_t             mon_ev;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_to = 1'b0;
      while (evq.size() > 0 && evq[0].edge_no < edge_cnt) begin
        mon_ev = evq.pop_front();
        chk("missed_event", 32'(mon_ev.edge_no), 32'(edge_cnt));
      end
      if (reset) begin
        mon_own = -1;
        mon_idx = 0;
      end else if (evq.size() > 0 && evq[0].edge_no == edge_cnt) begin
        mon_ev = evq.pop_front();
        if (mon_ev.is_grant) begin
          mon_own = mon_ev.idx;
          mon_idx = mon_ev.idx;
        end else begin
          mon_own = -1;
          mon_to  = mon_ev.to;
        end
      end
      mon_gnt = '0;
      if (mon_own >= 0) mon_gnt[mon_own] = 1'b1;
      chk("gnt", 32'(gnt), 32'(mon_gnt));
      chk("gnt_vld", 32'(gnt_vld), 32'(mon_own >= 0));
      chk("gnt_idx", 32'(gnt_idx), 32'(mon_idx));
      chk("timeout_err", 32'(timeout_err), 32'(mon_to));
    end
  end

  // Stimulus
  logic [DRVS-1:0] pn;
  initial begin
    foreach (m_quota[i]) m_quota[i] = 1;
    repeat (3) cyc(1, '0, 0, 0, 0, 0);
    // all terminals busy, quota 1: plain rotation
    repeat (60) cyc(0, 8'hFF, gdone(2), 0, 0, 0);
    // terminal 3 weighted to 3 packets
    cyc(0, '0, 0, 1, 3, 3);
    repeat (100) cyc(0, 8'b0000_1001, gdone(2), 0, 0, 0);
    // reset while granted, then sparse requesters with wrap
    repeat (3) cyc(0, 8'b0000_1001, 0, 0, 0, 0);
    cyc(1, 8'b0000_1001, 0, 0, 0, 0);
    repeat (40) cyc(0, 8'b0000_0101, gdone(2), 0, 0, 0);
    // zero quota written to whoever is granted
    repeat (30) cyc(0, 8'b0010_0100, gdone(2), m_owner >= 0, (m_owner >= 0) ? m_owner : 0, 0);
    // stalled datapath: watchdog releases
    repeat (120) cyc(0, 8'hFF, 0, 0, 0, 0);
    // fully random traffic, config writes and occasional reset
    pn = DRVS'($urandom);
    repeat (2000) begin
      if ($urandom_range(0, 3) == 0) pn[$urandom_range(0, DRVS-1)] ^= 1'b1;
      cyc($urandom_range(0, 149) == 0, pn, gdone(3), $urandom_range(0, 7) == 0,
          $urandom_range(0, DRVS-1), $urandom_range(0, 15));
    end
    repeat (5) cyc(0, '0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("evq_drained", 32'(evq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
